// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Elaboration-time helpers for the parameterised sequence
//                detector: KMP next-state function and parameter range checks.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int c_MAX_PAT_LEN = 16;
    localparam int c_MAX_CNT_W   = 32;

    // Legal pattern lengths.
    function automatic bit pat_len_ok(input int plen);
        return (plen >= 2) && (plen <= c_MAX_PAT_LEN);
    endfunction

    // Legal match-counter widths.
    function automatic bit cnt_w_ok(input int w);
        return (w >= 1) && (w <= c_MAX_CNT_W);
    endfunction

    // Next matched-prefix length after receiving bit d while s bits are matched.
    // pat holds the pattern right-aligned; pat[plen-1] is the first bit received.
    // The candidate text is the first s pattern bits followed by d (oldest first
    // in seq[0]); the result is the longest pattern prefix that is a suffix of it.
    // In non-overlapping mode a full match restarts detection from scratch.
    function automatic int next_state(
        input logic [15:0] pat,
        input int          plen,
        input int          s,
        input logic        d,
        input bit          overlap
    );
        logic [16:0] seq;
        int          len;
        int          res;
        bit          hit;
        res = 0;
        seq = '0;
        len = 0;
        hit = 1'b0;
        if ((s == plen) && !overlap) begin
            res = (d == pat[plen-1]) ? 1 : 0;
        end else begin
            for (int i = 0; i < s; i++) begin
                seq[i] = pat[plen-1-i];
            end
            seq[s] = d;
            len    = s + 1;
            // Ascending search so the last hit is the longest match.
            for (int k = 1; k <= plen; k++) begin
                if (k <= len) begin
                    hit = 1'b1;
                    for (int j = 0; j < k; j++) begin
                        if (seq[len-k+j] != pat[plen-1-j]) begin
                            hit = 1'b0;
                        end
                    end
                    if (hit) begin
                        res = k;
                    end
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sat_cnt
//  Description : Saturating up-counter with synchronous clear; clear has
//                priority over increment. Asynchronous active-high reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] c_MAX = '1;

    logic [W-1:0] r_cnt_q;
    logic [W-1:0] w_cnt_d;

    // Next count: clear wins, otherwise increment until the all-ones ceiling.
    always_comb begin
        w_cnt_d = r_cnt_q;
        if (clr) begin
            w_cnt_d = '0;
        end else if (inc && (r_cnt_q != c_MAX)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign cnt = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Parameterised serial pattern detector. State is the number of
//                pattern bits currently matched (KMP automaton, table built at
//                elaboration); Q is a registered Moore "full match" flag and
//                match_cnt a saturating count of completed matches.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = '0,
    parameter int                 OVERLAP = 1,
    parameter int                 CNT_W   = 8,
    localparam int                SW      = $clog2(PAT_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             D,
    input  logic             clr_cnt,
    output logic             Q,
    output logic [CNT_W-1:0] match_cnt,
    output logic [SW-1:0]    state_dbg
);

    localparam logic [15:0]   c_PAT16 = 16'(PATTERN);
    localparam logic [SW-1:0] c_FULL  = SW'(PAT_LEN);

    // Reject out-of-range parameters at elaboration.
    if (!pat_len_ok(PAT_LEN)) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN must be within 2..16");
    end
    if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W must be within 1..32");
    end

    // Constant transition table indexed by [state][bit].
    logic [SW-1:0] w_nxt_tbl [0:PAT_LEN][0:1];

    for (genvar gs = 0; gs <= PAT_LEN; gs++) begin : g_tbl_s
        for (genvar gd = 0; gd < 2; gd++) begin : g_tbl_d
            localparam int c_NXT = next_state(c_PAT16, PAT_LEN, gs, 1'(gd), OVERLAP != 0);
            assign w_nxt_tbl[gs][gd] = SW'(c_NXT);
        end
    end

    logic [SW-1:0] r_state_q;
    logic [SW-1:0] w_state_d;
    logic          r_q_q;
    logic          w_q_d;
    logic          w_inc;

    // Next state from the table when sampling; match flag tracks the FULL state.
    always_comb begin
        w_state_d = r_state_q;
        if (en) begin
            w_state_d = w_nxt_tbl[r_state_q][D];
        end
        w_q_d = (r_state_q == c_FULL);
        w_inc = en && (w_state_d == c_FULL);
    end

    // State and match-flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= '0;
            r_q_q     <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_q_q     <= w_q_d;
        end
    end

    sat_cnt #(
        .W (CNT_W)
    ) u_sat_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_inc),
        .clr (clr_cnt),
        .cnt (match_cnt)
    );

    assign Q         = r_q_q;
    assign state_dbg = r_state_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detector_param
//  Description : Self-checking bench for seq_detector_param. Four instances
//                (defaults, non-overlapping, 4-bit 1011, 2-bit counter) share
//                one stimulus stream and are checked against a history-based
//                pattern-matching model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic d   = 1'b0;
    logic clr = 1'b0;

    logic       q0, q1, q2, q3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;
    logic [1:0] s0, s1, s3;
    logic [2:0] s2;

    always #5 clk = ~clk;

    seq_detector_param u_def (
        .clk(clk), .rst(rst), .en(en), .D(d), .clr_cnt(clr),
        .Q(q0), .match_cnt(c0), .state_dbg(s0)
    );
    seq_detector_param #(.OVERLAP(0)) u_nov (
        .clk(clk), .rst(rst), .en(en), .D(d), .clr_cnt(clr),
        .Q(q1), .match_cnt(c1), .state_dbg(s1)
    );
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011)) u_p4 (
        .clk(clk), .rst(rst), .en(en), .D(d), .clr_cnt(clr),
        .Q(q2), .match_cnt(c2), .state_dbg(s2)
    );
    seq_detector_param #(.OVERLAP(0), .CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .en(en), .D(d), .clr_cnt(clr),
        .Q(q3), .match_cnt(c3), .state_dbg(s3)
    );

    logic [3:0] act_state [4];
    logic       act_q     [4];
    logic [7:0] act_cnt   [4];

    assign act_state[0] = 4'(s0);
    assign act_state[1] = 4'(s1);
    assign act_state[2] = 4'(s2);
    assign act_state[3] = 4'(s3);
    assign act_q[0] = q0;
    assign act_q[1] = q1;
    assign act_q[2] = q2;
    assign act_q[3] = q3;
    assign act_cnt[0] = c0;
    assign act_cnt[1] = c1;
    assign act_cnt[2] = c2;
    assign act_cnt[3] = 8'(c3);

    // Per-instance configuration.
    int          PL  [4] = '{3, 3, 4, 3};
    logic [15:0] PAT [4] = '{16'h0000, 16'h0000, 16'h000B, 16'h0000};
    int          OV  [4] = '{1, 0, 1, 0};
    int          CW  [4] = '{8, 8, 8, 2};

    // Reference model: received-bit history (bit 0 newest) and derived outputs.
    logic [31:0] m_hist  [4];
    int          m_hlen  [4];
    int          m_state [4];
    bit          m_q     [4];
    int          m_cnt   [4];

    int vec = 0;
    int err = 0;

    // Longest pattern prefix that ends the history.
    function automatic int longest(input logic [31:0] h, input int hl,
                                   input logic [15:0] p, input int pl);
        int best;
        bit ok;
        best = 0;
        for (int k = 1; k <= pl; k++) begin
            if (k <= hl) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (h[k-1-j] !== p[pl-1-j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_hist[i]  = '0;
            m_hlen[i]  = 0;
            m_state[i] = 0;
            m_q[i]     = 1'b0;
            m_cnt[i]   = 0;
        end
    endtask

    // One rising edge with the current en/d/clr.
    task automatic model_edge();
        int k;
        bit nq;
        for (int i = 0; i < 4; i++) begin
            nq = (m_state[i] == PL[i]);
            k  = m_state[i];
            if (en) begin
                m_hist[i] = {m_hist[i][30:0], d};
                if (m_hlen[i] < 32) m_hlen[i] = m_hlen[i] + 1;
                k = longest(m_hist[i], m_hlen[i], PAT[i], PL[i]);
                // Without overlap, a completed match forgets everything before it.
                if (OV[i] == 0 && k == PL[i]) m_hlen[i] = 0;
            end
            if (clr) m_cnt[i] = 0;
            else if (en && k == PL[i] && m_cnt[i] < ((1 << CW[i]) - 1)) m_cnt[i] = m_cnt[i] + 1;
            m_state[i] = k;
            m_q[i]     = nq;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; d = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Apply one sampled cycle; returns 1 time unit after the rising edge.
    task automatic step(input logic e, input logic dd, input logic cl);
        @(negedge clk);
        en = e; d = dd; clr = cl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (act_state[i] !== 4'd0 || act_q[i] !== 1'b0 || act_cnt[i] !== 8'd0) begin
                err++;
                $display("FAIL reset inst%0d: state=%0d q=%0d cnt=%0d, expected all 0",
                         i, act_state[i], act_q[i], act_cnt[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Four zeros: overlapping stays FULL, non-overlapping restarts.
    task automatic test_zeros();
        int exp0 [4] = '{1, 2, 3, 3};
        int exp1 [4] = '{1, 2, 3, 1};
        do_reset();
        for (int n = 0; n < 4; n++) begin
            step(1'b1, 1'b0, 1'b0);
            vec++;
            if (act_state[0] !== 4'(exp0[n]) || act_state[1] !== 4'(exp1[n])) begin
                err++;
                $display("FAIL zeros_state edge%0d: ovl=%0d novl=%0d, expected %0d %0d",
                         n + 1, act_state[0], act_state[1], exp0[n], exp1[n]);
            end
            for (int i = 0; i < 4; i++) begin
                vec++;
                if (act_state[i] !== 4'(m_state[i]) || act_q[i] !== m_q[i] || act_cnt[i] !== 8'(m_cnt[i])) begin
                    err++;
                    $display("FAIL zeros_model inst%0d: state=%0d q=%0d cnt=%0d, expected %0d %0d %0d",
                             i, act_state[i], act_q[i], act_cnt[i], m_state[i], m_q[i], m_cnt[i]);
                end
            end
        end
        step(1'b0, 1'b0, 1'b0);
        vec++;
        if (act_q[0] !== 1'b1 || act_q[1] !== 1'b0 || act_cnt[0] !== 8'd2 || act_cnt[1] !== 8'd1) begin
            err++;
            $display("FAIL zeros_final: q=%0d/%0d cnt=%0d/%0d, expected 1/0 2/1",
                     act_q[0], act_q[1], act_cnt[0], act_cnt[1]);
        end
    endtask

    // 1,0,1,0,1,1 against 1011 exercises KMP fallback to a partial match.
    task automatic test_kmp();
        logic [5:0] bits = 6'b101011;
        int         exp2 [6] = '{1, 2, 3, 2, 3, 4};
        do_reset();
        for (int n = 0; n < 6; n++) begin
            step(1'b1, bits[5-n], 1'b0);
            vec++;
            if (act_state[2] !== 4'(exp2[n]) || act_state[2] !== 4'(m_state[2])) begin
                err++;
                $display("FAIL kmp_state edge%0d: state=%0d, expected %0d",
                         n + 1, act_state[2], exp2[n]);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        vec++;
        if (act_q[2] !== 1'b1 || act_cnt[2] !== 8'd1) begin
            err++;
            $display("FAIL kmp_match: q=%0d cnt=%0d, expected q=1 cnt=1", act_q[2], act_cnt[2]);
        end
    endtask

    // en=0 holds the partial match while D toggles.
    task automatic test_en_hold();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step(1'b0, 1'b1, 1'b0);
            vec++;
            if (act_state[0] !== 4'd2 || act_q[0] !== 1'b0 || act_cnt[0] !== 8'd0) begin
                err++;
                $display("FAIL en_hold cyc%0d: state=%0d q=%0d cnt=%0d, expected 2 0 0",
                         n, act_state[0], act_q[0], act_cnt[0]);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        vec++;
        if (act_state[0] !== 4'd3 || act_cnt[0] !== 8'd1) begin
            err++;
            $display("FAIL en_resume: state=%0d cnt=%0d, expected 3 1", act_state[0], act_cnt[0]);
        end
    endtask

    // 2-bit counter saturates at 3; clear beats a coincident match.
    task automatic test_sat();
        int expc [5] = '{1, 2, 3, 3, 3};
        do_reset();
        for (int m = 0; m < 5; m++) begin
            for (int b = 0; b < 3; b++) step(1'b1, 1'b0, 1'b0);
            vec++;
            if (act_cnt[3] !== 8'(expc[m]) || act_cnt[3] !== 8'(m_cnt[3])) begin
                err++;
                $display("FAIL sat_cnt match%0d: cnt=%0d, expected %0d", m + 1, act_cnt[3], expc[m]);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        vec++;
        if (act_cnt[3] !== 8'd0 || act_state[3] !== 4'd3) begin
            err++;
            $display("FAIL clr_priority: cnt=%0d state=%0d, expected 0 3", act_cnt[3], act_state[3]);
        end
    endtask

    // Reset between edges discards a partial match immediately.
    task automatic test_async_reset();
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        vec++;
        if (act_state[0] !== 4'd2) begin
            err++;
            $display("FAIL arst_pre: state=%0d, expected 2", act_state[0]);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (act_state[i] !== 4'd0 || act_q[i] !== 1'b0 || act_cnt[i] !== 8'd0) begin
                err++;
                $display("FAIL arst inst%0d: state=%0d q=%0d cnt=%0d, expected all 0",
                         i, act_state[i], act_q[i], act_cnt[i]);
            end
        end
        rst = 1'b0;
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0);
        vec++;
        if (act_state[0] !== 4'd3 || act_cnt[0] !== 8'd1) begin
            err++;
            $display("FAIL arst_post: state=%0d cnt=%0d, expected 3 1", act_state[0], act_cnt[0]);
        end
    endtask

    // Random en/D/clr with occasional mid-cycle resets.
    task automatic test_random();
        logic e, dd, cl;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            e  = ($urandom_range(0, 3) != 0);
            dd = 1'($urandom_range(0, 1));
            cl = ($urandom_range(0, 24) == 0);
            step(e, dd, cl);
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1 rst = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                vec++;
                if (act_state[i] !== 4'(m_state[i]) || act_q[i] !== m_q[i] || act_cnt[i] !== 8'(m_cnt[i])) begin
                    err++;
                    $display("FAIL random cyc%0d inst%0d: state=%0d q=%0d cnt=%0d, expected %0d %0d %0d",
                             n, i, act_state[i], act_q[i], act_cnt[i], m_state[i], m_q[i], m_cnt[i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_zeros();
        test_kmp();
        test_en_hold();
        test_sat();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 3: pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter PATTERN, default 3'b000 (PAT_LEN bits): target sequence; PATTERN[PAT_LEN-1] is the first bit received.
REQ-003 The block SHALL have parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = detection restarts after each match.
REQ-004 The block SHALL have parameter CNT_W, default 8: match-counter width, legal range 1..32.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: D is sampled only when en=1.
REQ-008 The block SHALL have port D, input, 1 bit: serial data bit.
REQ-009 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of match_cnt.
REQ-010 The block SHALL have port Q, output, 1 bit: registered Moore match flag.
REQ-011 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-012 The block SHALL have port state_dbg, output, SW = $clog2(PAT_LEN+1) bits: current state, for debug.

Function
REQ-013 State s SHALL be in 0..PAT_LEN, meaning the number of pattern bits currently matched; PAT_LEN is the FULL state.
REQ-014 When en=0, state, Q source and match_cnt SHALL hold.
REQ-015 When en=1 and s<PAT_LEN, next state SHALL be the length of the longest PATTERN prefix that is a suffix of (first s pattern bits followed by D), i.e. KMP fallback, not a reset to 0.
REQ-016 When en=1 and s=PAT_LEN with OVERLAP=1, next state SHALL be computed per REQ-015 over (full pattern followed by D).
REQ-017 When en=1 and s=PAT_LEN with OVERLAP=0, next state SHALL be 1 if D=PATTERN[PAT_LEN-1], else 0.
REQ-018 The transition table SHALL be computed at elaboration and SHALL contain no run-time search logic.
REQ-019 Q SHALL be the register of (state==PAT_LEN).
REQ-020 If the last pattern bit is sampled at edge N, Q SHALL be 1 after edge N+1.
REQ-021 Q SHALL remain 1 while the state stays FULL, including while en=0.
REQ-022 match_cnt SHALL increment by 1 on each edge where en=1 and next state = PAT_LEN.
REQ-023 match_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 When clr_cnt=1, match_cnt SHALL become 0 on the next edge; clr_cnt SHALL win over a simultaneous increment.
REQ-025 state_dbg SHALL equal the state register directly.

Reset
REQ-026 While rst=1, state SHALL be 0, Q SHALL be 0 and match_cnt SHALL be 0, asynchronously and regardless of clk.
REQ-027 Reset asserted mid-pattern SHALL discard the partial match; the first sampled bit after rst falls SHALL be treated as a fresh sequence start.

Structure
REQ-028 Package seq_det_pkg SHALL hold the elaboration-time next-state/fallback function and the parameter legality checks (PAT_LEN range, CNT_W range).
REQ-029 Illegal parameter values SHALL cause an elaboration error.
REQ-030 The saturating counter SHALL be one sub-module, sat_cnt (parameter W; inputs inc and clr; clr priority).
REQ-031 The FSM, next-state logic and Q register SHALL reside in seq_detector_param.

Verification
REQ-032 Defaults, en=1, D=0,0,0,0: state SHALL go 1,2,3,3; Q SHALL be high for 2 cycles starting one edge after state 3 is reached; match_cnt SHALL be 2.
REQ-033 OVERLAP=0, D=0,0,0,0: state SHALL go 1,2,3,1; Q SHALL be high for 1 cycle; match_cnt SHALL be 1.
REQ-034 PAT_LEN=4, PATTERN=4'b1011, D=1,0,1,0,1,1: state SHALL go 1,2,3,2,3,4; exactly one match SHALL occur; Q=1 one edge after the final 1.
REQ-035 Defaults, D=0,0 with en=1, then en=0 for 3 cycles with D=1, then D=0 with en=1: state SHALL hold at 2, then reach 3; match_cnt SHALL be 1.
REQ-036 CNT_W=2, 5 non-overlapping matches: match_cnt SHALL go 1,2,3,3,3; clr_cnt asserted on the same edge as a match increment SHALL yield 0.
REQ-037 rst pulse asynchronously between edges while state=2: state, Q and match_cnt SHALL be 0 immediately; then D=0,0,0 SHALL yield a match.
